// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the iterative restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int DIV_DEFAULT_BITLEN = 17;

  // Counter must hold BITLEN-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor, and keep the difference only when it is non-negative.
module div_step #(
  parameter int BITLEN = 17
) (
  input  logic [BITLEN:0]   rem,
  input  logic              quo_msb,
  input  logic [BITLEN-1:0] divisor,
  output logic [BITLEN:0]   rem_next,
  output logic              q_bit
);

  logic [BITLEN:0]   shifted;
  logic [BITLEN+1:0] diff;

  // A set rem MSB would make the shifted value exceed any divisor, so it forces a 1.
  always_comb begin
    shifted = {rem[BITLEN-1:0], quo_msb};
    diff    = {1'b0, shifted} - {2'b00, divisor};
    q_bit   = rem[BITLEN] | ~diff[BITLEN+1];
    if (q_bit) begin
      rem_next = diff[BITLEN:0];
    end else begin
      rem_next = shifted;
    end
  end

endmodule

// File: rtl/div_iter.sv
// Sequential unsigned restoring divider, one quotient bit per cycle, with
// valid/ready handshakes. Optional macro DIV_ITER_EARLY_OUT_EN enables a
// one-cycle result when A<=B.
module div_iter
  import div_pkg::*;
#(
  parameter int BITLEN = DIV_DEFAULT_BITLEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BITLEN-1:0] A,
  input  logic [BITLEN-1:0] B,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BITLEN-1:0] Q,
  output logic [BITLEN-1:0] R,
  output logic              div_by_zero
);

  localparam int CW = cnt_width(BITLEN);

  div_state_e        state;
  div_state_e        state_next;
  logic [BITLEN:0]   rem;
  logic [BITLEN:0]   rem_next;
  logic [BITLEN-1:0] quo;
  logic [BITLEN-1:0] divisor;
  logic [CW-1:0]     cnt;
  logic              q_bit;
  logic              early_done;

`ifdef DIV_ITER_EARLY_OUT_EN
  assign early_done = (B != '0) && (A <= B);
`else
  assign early_done = 1'b0;
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  div_step #(.BITLEN(BITLEN)) u_step (
    .rem      (rem),
    .quo_msb  (quo[BITLEN-1]),
    .divisor  (divisor),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; DONE always returns through IDLE, so no accept/retire overlap.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if ((B == '0) || early_done) begin
            state_next = DONE;
          end else begin
            state_next = CALC;
          end
        end else begin
          state_next = IDLE;
        end
      end
      CALC: begin
        if (cnt == '0) begin
          state_next = DONE;
        end else begin
          state_next = CALC;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end else begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, and result registers held through DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem         <= '0;
      quo         <= '0;
      divisor     <= '0;
      cnt         <= '0;
      Q           <= '0;
      R           <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            rem     <= '0;
            quo     <= A;
            divisor <= B;
            cnt     <= CW'(BITLEN - 1);
            if (B == '0) begin
              Q           <= '1;
              R           <= A;
              div_by_zero <= 1'b1;
            end else if (early_done) begin
              div_by_zero <= 1'b0;
              if (A == B) begin
                Q <= {{(BITLEN-1){1'b0}}, 1'b1};
                R <= '0;
              end else begin
                Q <= '0;
                R <= A;
              end
            end else begin
              div_by_zero <= 1'b0;
            end
          end else begin
            cnt <= cnt;
          end
        end
        CALC: begin
          rem <= rem_next;
          quo <= {quo[BITLEN-2:0], q_bit};
          cnt <= cnt - CW'(1);
          if (cnt == '0) begin
            Q <= {quo[BITLEN-2:0], q_bit};
            R <= rem_next[BITLEN-1:0];
          end else begin
            R <= R;
          end
        end
        DONE: begin
          Q <= Q;
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: scoreboard of expected results, latency,
// backpressure, divide-by-zero and asynchronous reset mid-operation.
module tb_div_iter;

  localparam int W = 17;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Q;
  logic [W-1:0] R;
  logic         div_by_zero;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  div_iter #(.BITLEN(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .A          (A),
    .B          (B),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .Q          (Q),
    .R          (R),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == '0) return 1;
`ifdef DIV_ITER_EARLY_OUT_EN
    if (a <= b) return 1;
`endif
    return 18;
  endfunction

  // Issue one operation, wait for its result, compare against the scoreboard,
  // optionally hold out_ready low for 'hold' cycles while poking in_valid.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic edbz, input int hold);
    exp_t e;
    exp_t got;
    int   lat;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL in_ready_before_op: got %b want 1", in_ready);
    end
    in_valid = 1'b1;
    A = a;
    B = b;
    e.q = eq; e.r = er; e.dbz = edbz; e.lat = exp_lat(a, b);
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A = W'($urandom);
    B = W'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (out_valid !== 1'b1 && lat < 100);
    got = sb.pop_front();
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout: out_valid not seen for A=%0d B=%0d within %0d cycles", a, b, lat);
    end else begin
      if (lat != got.lat) begin
        n_fail++;
        $display("FAIL latency A=%0d B=%0d: got %0d want %0d", a, b, lat, got.lat);
      end
    end
    n_checks++;
    if (Q !== got.q) begin
      n_fail++;
      $display("FAIL quotient A=%0d B=%0d: got %0d want %0d", a, b, Q, got.q);
    end
    n_checks++;
    if (R !== got.r) begin
      n_fail++;
      $display("FAIL remainder A=%0d B=%0d: got %0d want %0d", a, b, R, got.r);
    end
    n_checks++;
    if (div_by_zero !== got.dbz) begin
      n_fail++;
      $display("FAIL div_by_zero A=%0d B=%0d: got %b want %b", a, b, div_by_zero, got.dbz);
    end
    for (int k = 0; k < hold; k++) begin
      in_valid = k[0];
      A = 17'd1;
      B = 17'd1;
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || Q !== got.q || R !== got.r ||
          div_by_zero !== got.dbz) begin
        n_fail++;
        $display("FAIL hold_stable cycle %0d: ov=%b ir=%b Q=%0d R=%0d dbz=%b want ov=1 ir=0 Q=%0d R=%0d dbz=%b",
                 k, out_valid, in_ready, Q, R, div_by_zero, got.q, got.r, got.dbz);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL after_retire: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    if (hold > 0) begin
      repeat (3) @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL ignored_pulses: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0;
    #12;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || Q !== '0 || R !== '0 || div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: ir=%b ov=%b Q=%0d R=%0d dbz=%b want 1 0 0 0 0",
               in_ready, out_valid, Q, R, div_by_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_nominal();
    run_op(17'd100000, 17'd7, 17'd14285, 17'd5, 1'b0, 0);
  endtask

  task automatic test_max_operands();
    run_op(17'd131071, 17'd1, 17'd131071, 17'd0, 1'b0, 0);
    run_op(17'd131071, 17'd131071, 17'd1, 17'd0, 1'b0, 0);
  endtask

  task automatic test_div_by_zero();
    run_op(17'd5, 17'd0, 17'h1FFFF, 17'd5, 1'b1, 0);
    run_op(17'd9, 17'd3, 17'd3, 17'd0, 1'b0, 0);
  endtask

  task automatic test_small_dividend();
    run_op(17'd3, 17'd10, 17'd0, 17'd3, 1'b0, 0);
  endtask

  task automatic test_backpressure();
    run_op(17'd100000, 17'd7, 17'd14285, 17'd5, 1'b0, 5);
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    in_valid = 1'b1;
    A = 17'd100000;
    B = 17'd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || Q !== '0 || R !== '0 || div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_op: ov=%b ir=%b Q=%0d R=%0d dbz=%b want 0 1 0 0 0",
               out_valid, in_ready, Q, R, div_by_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_discard: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    run_op(17'd1000, 17'd33, 17'd30, 17'd10, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a;
    logic [W-1:0] b;
    for (int i = 0; i < 8; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      if (i % 3 == 0) b = b >> 12;
      if (i == 4) b = '0;
      if (i == 5) b = a + 17'd1;
      if (b == '0)
        run_op(a, b, '1, a, 1'b1, 0);
      else
        run_op(a, b, a / b, a % b, 1'b0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_max_operands();
    test_div_by_zero();
    test_small_dividend();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
